// File: rtl/sram_loop_driver_if.sv
// rtl/sram_loop_driver_if.sv - single-port SRAM access bus between loop driver and SRAM
interface sram_loop_driver_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] addr;
    logic              ren;
    logic              wen;
    logic [WIDTH-1:0]  d;
    logic [WIDTH-1:0]  q;

    modport master (output addr, output ren, output wen, output d, input q);
    modport slave  (input addr, input ren, input wen, input d, output q);
endinterface

// File: rtl/sram_loop_driver.sv
// rtl/sram_loop_driver.sv - two-level pipelined loop-nest driver issuing one SRAM access every II cycles
module sram_loop_driver #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int N_OUTER  = 4,
    parameter int N_INNER  = 8,
    parameter int II       = 1,
    parameter int STRIDE   = 8,
    parameter int BASE     = 0,
    parameter int IS_WRITE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [31:0]       iter_i,
    output logic [31:0]       iter_j,
    output logic              busy,
    output logic              done,
    sram_loop_driver_if.master sram
);
    localparam int   ADDR_W = $clog2(DEPTH);
    localparam logic WR_MODE = (IS_WRITE != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] i_q, i_d;
    logic [31:0] j_q, j_d;
    logic [31:0] ii_cnt_q, ii_cnt_d;
    logic        rd_valid_q, rd_valid_d;

    logic        access;
    logic        last;
    logic        ren;
    logic        wen;

    // An access slot is the first cycle of each II window that is not stalled.
    assign access = (state_q == S_RUN) && (ii_cnt_q == 32'd0) && !stall;
    assign last   = (i_q == 32'(N_OUTER - 1)) && (j_q == 32'(N_INNER - 1));
    assign ren    = access && !WR_MODE;
    assign wen    = access && WR_MODE;

    // Next-state, loop indices and II counter.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        ii_cnt_d   = ii_cnt_q;
        rd_valid_d = ren;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    i_d      = '0;
                    j_d      = '0;
                    ii_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    ii_cnt_d = (ii_cnt_q == 32'(II - 1)) ? 32'd0 : ii_cnt_q + 32'd1;
                end
                if (access) begin
                    // The final access leaves i/j on the last iteration so they read back after the sweep.
                    if (last) begin
                        state_d = S_DRAIN;
                    end else if (j_q == 32'(N_INNER - 1)) begin
                        j_d = '0;
                        i_d = i_q + 32'd1;
                    end else begin
                        j_d = j_q + 32'd1;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any sweep, including an outstanding read return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            ii_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            ii_cnt_q   <= ii_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign sram.addr = ADDR_W'(32'(BASE) + i_q * 32'(STRIDE) + j_q);
    assign sram.ren  = ren;
    assign sram.wen  = wen;
    assign sram.d    = wr_data;

    assign wr_ready = wen;
    assign rd_data  = sram.q;
    assign rd_valid = rd_valid_q;
    assign iter_i   = i_q;
    assign iter_j   = j_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DRAIN);
endmodule

// File: tb/tb_sram_loop_driver.sv
// tb/tb_sram_loop_driver.sv - scoreboard testbench for sram_loop_driver
module tb_sram_loop_driver;
    localparam int K_ACC  = 0;
    localparam int K_WRR  = 1;
    localparam int K_RDV  = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int          dut;
        int          kind;
        int          cyc;
        logic [31:0] val;
    } ev_t;

    typedef int arr6_t[6];

    logic clk;
    int   cyc;
    int   t0;
    int   checks;
    int   errors;
    ev_t  expq[$];

    logic rst_a, rst_b, rst_c;
    logic start_a, start_b, start_c;
    logic stall_a, stall_b, stall_c;
    logic [31:0] wr_data;

    logic        wr_ready_a, wr_ready_b, wr_ready_c;
    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic [31:0] iter_i_a, iter_i_b, iter_i_c;
    logic [31:0] iter_j_a, iter_j_b, iter_j_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    arr6_t exp_addr = '{0, 1, 2, 8, 9, 10};

    sram_loop_driver_if #(.WIDTH(32), .ADDR_W(5)) a_if ();
    sram_loop_driver_if #(.WIDTH(32), .ADDR_W(5)) b_if ();
    sram_loop_driver_if #(.WIDTH(32), .ADDR_W(4)) c_if ();

    sram_loop_driver #(.WIDTH(32), .DEPTH(32), .N_OUTER(2), .N_INNER(3), .II(1),
                       .STRIDE(8), .BASE(0), .IS_WRITE(0)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .stall(stall_a), .wr_data(wr_data),
        .wr_ready(wr_ready_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .iter_i(iter_i_a), .iter_j(iter_j_a), .busy(busy_a), .done(done_a), .sram(a_if.master)
    );

    sram_loop_driver #(.WIDTH(32), .DEPTH(32), .N_OUTER(2), .N_INNER(3), .II(3),
                       .STRIDE(8), .BASE(0), .IS_WRITE(0)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stall(stall_b), .wr_data(wr_data),
        .wr_ready(wr_ready_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .iter_i(iter_i_b), .iter_j(iter_j_b), .busy(busy_b), .done(done_b), .sram(b_if.master)
    );

    sram_loop_driver #(.WIDTH(32), .DEPTH(16), .N_OUTER(1), .N_INNER(4), .II(1),
                       .STRIDE(8), .BASE(14), .IS_WRITE(1)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .stall(stall_c), .wr_data(wr_data),
        .wr_ready(wr_ready_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
        .iter_i(iter_i_c), .iter_j(iter_j_c), .busy(busy_c), .done(done_c), .sram(c_if.master)
    );

    function automatic logic [31:0] rdat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write data tags each cycle relative to the sweep start.
    assign wr_data = 32'hBEEF_0000 + 32'(cyc - t0);

    // SRAM models: read data is a known function of the address, one cycle after ren.
    always @(posedge clk) if (a_if.ren) a_if.q <= rdat(32'(a_if.addr));
    always @(posedge clk) if (b_if.ren) b_if.q <= rdat(32'(b_if.addr));
    assign c_if.q = '0;

    task automatic push(input int dut, input int kind, input int c, input logic [31:0] val);
        ev_t e;
        int  idx;
        e.dut = dut; e.kind = kind; e.cyc = c; e.val = val;
        idx = expq.size();
        for (int n = 0; n < expq.size(); n++) begin
            if (expq[n].cyc * 8 + expq[n].kind > c * 8 + kind) begin
                idx = n;
                break;
            end
        end
        expq.insert(idx, e);
    endtask

    task automatic push_read(input int dut, input arr6_t ac, input int done_c);
        for (int k = 0; k < 6; k++) begin
            push(dut, K_ACC, ac[k], 32'(exp_addr[k]));
            push(dut, K_RDV, ac[k] + 1, rdat(exp_addr[k]));
        end
        push(dut, K_DONE, done_c, 32'd0);
    endtask

    task automatic observe(input int dut, input int kind, input int r, input logic [31:0] val);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got dut=%0d kind=%0d cyc=%0d val=%h, required no event", dut, kind, r, val);
        end else begin
            e = expq.pop_front();
            if (e.dut != dut || e.kind != kind || e.cyc != r || e.val != val) begin
                errors++;
                $display("FAIL event: got dut=%0d kind=%0d cyc=%0d val=%h, required dut=%0d kind=%0d cyc=%0d val=%h",
                         dut, kind, r, val, e.dut, e.kind, e.cyc, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_empty(input string name);
        chk(name, 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every presented output event is matched against the scoreboard.
    always @(negedge clk) begin
        int r;
        r = cyc - t0;
        if (a_if.ren || a_if.wen) observe(0, K_ACC, r, 32'(a_if.addr));
        if (wr_ready_a)           observe(0, K_WRR, r, a_if.d);
        if (rd_valid_a)           observe(0, K_RDV, r, rd_data_a);
        if (done_a)               observe(0, K_DONE, r, 32'd0);
        if (b_if.ren || b_if.wen) observe(1, K_ACC, r, 32'(b_if.addr));
        if (wr_ready_b)           observe(1, K_WRR, r, b_if.d);
        if (rd_valid_b)           observe(1, K_RDV, r, rd_data_b);
        if (done_b)               observe(1, K_DONE, r, 32'd0);
        if (c_if.ren || c_if.wen) observe(2, K_ACC, r, 32'(c_if.addr));
        if (wr_ready_c)           observe(2, K_WRR, r, c_if.d);
        if (rd_valid_c)           observe(2, K_RDV, r, rd_data_c);
        if (done_c)               observe(2, K_DONE, r, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; t0 = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0;
        tick(2);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_ren_a", 32'(a_if.ren), 32'd0);
        chk("reset_addr_a", 32'(a_if.addr), 32'd0);
        chk("reset_addr_c", 32'(c_if.addr), 32'd14);
        chk("reset_wen_c", 32'(c_if.wen), 32'd0);
        chk("reset_iter_i_a", iter_i_a, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick(1);

        // Read sweep, II=1.
        push_read(0, '{1, 2, 3, 4, 5, 6}, 7);
        t0 = cyc; start_a = 1'b1;
        tick(1); start_a = 1'b0;
        tick(6);
        chk("t1_busy_c7", 32'(busy_a), 32'd1);
        tick(1);
        chk("t1_busy_c8", 32'(busy_a), 32'd0);
        chk("t1_final_i", iter_i_a, 32'd1);
        chk("t1_final_j", iter_j_a, 32'd2);
        tick(2);
        check_empty("t1_leftover");

        // Read sweep, II=3.
        push_read(1, '{1, 4, 7, 10, 13, 16}, 17);
        t0 = cyc; start_b = 1'b1;
        tick(1); start_b = 1'b0;
        tick(20);
        check_empty("t2_leftover");

        // Stall in cycles 3-4.
        push_read(0, '{1, 2, 5, 6, 7, 8}, 9);
        t0 = cyc; start_a = 1'b1;
        tick(1); start_a = 1'b0;
        tick(2); stall_a = 1'b1;
        tick(2); stall_a = 1'b0;
        tick(7);
        check_empty("t3_leftover");

        // Write sweep with address wrap.
        push(2, K_ACC, 1, 32'd14); push(2, K_WRR, 1, 32'hBEEF_0001);
        push(2, K_ACC, 2, 32'd15); push(2, K_WRR, 2, 32'hBEEF_0002);
        push(2, K_ACC, 3, 32'd0);  push(2, K_WRR, 3, 32'hBEEF_0003);
        push(2, K_ACC, 4, 32'd1);  push(2, K_WRR, 4, 32'hBEEF_0004);
        push(2, K_DONE, 5, 32'd0);
        t0 = cyc; start_c = 1'b1;
        tick(1); start_c = 1'b0;
        tick(7);
        check_empty("t4_leftover");

        // Asynchronous reset after the third access.
        push(0, K_ACC, 1, 32'd0); push(0, K_ACC, 2, 32'd1); push(0, K_ACC, 3, 32'd2);
        push(0, K_RDV, 2, rdat(0)); push(0, K_RDV, 3, rdat(1));
        t0 = cyc; start_a = 1'b1;
        tick(1); start_a = 1'b0;
        tick(3);
        chk("t5_ren_before_rst", 32'(a_if.ren), 32'd1);
        chk("t5_rdv_before_rst", 32'(rd_valid_a), 32'd1);
        #2 rst_a = 1'b1;
        #1;
        chk("t5_ren_async", 32'(a_if.ren), 32'd0);
        chk("t5_busy_async", 32'(busy_a), 32'd0);
        chk("t5_rdv_async", 32'(rd_valid_a), 32'd0);
        tick(1); rst_a = 1'b0;
        tick(3);
        check_empty("t5_abort_leftover");
        push_read(0, '{1, 2, 3, 4, 5, 6}, 7);
        t0 = cyc; start_a = 1'b1;
        tick(1); start_a = 1'b0;
        tick(9);
        check_empty("t5_restart_leftover");

        // start held high: back-to-back sweeps with one IDLE cycle between.
        push_read(0, '{1, 2, 3, 4, 5, 6}, 7);
        push_read(0, '{9, 10, 11, 12, 13, 14}, 15);
        t0 = cyc; start_a = 1'b1;
        tick(8);
        chk("t6_idle_gap_busy", 32'(busy_a), 32'd0);
        tick(2); start_a = 1'b0;
        tick(8);
        check_empty("t6_leftover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
